byte_packer_clkb: RTL

Read-side consumer of `asynchronous_fifo`, in the `clkb` domain. It drains bytes from the FIFO by driving `rd_en_clkb` from `empty_clkb`, and packs them little-endian into `BYTES_PER_WORD`-byte words. Words go out on a valid/ready interface. A partial word is flushed after an idle timeout, so trailing bytes of a burst are never stranded.

---
 rtl/byte_packer_pkg.sv | 9 +
 rtl/byte_packer_clkb_idle_timer.sv | 18 +
 rtl/byte_packer_clkb.sv | 61 ++++++
 3 files changed

// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: shared constants and the word_bytes width helper for byte_packer_clkb
package byte_packer_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_IDLE_TIMEOUT = 16;
  function automatic int word_bytes_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/byte_packer_clkb_idle_timer.sv
// idle_timer: saturating idle counter; hit flags that IDLE_TIMEOUT idle cycles have elapsed
module idle_timer #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic clkb,
  input  logic resetb_clkb,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int W = $clog2(IDLE_TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign hit = cnt == W'(IDLE_TIMEOUT);
  always_ff @(posedge clkb or negedge resetb_clkb)
    if (!resetb_clkb) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !hit) cnt <= cnt + W'(1);
endmodule

// File: rtl/byte_packer_clkb.sv
// byte_packer_clkb: drains an async FIFO read side and packs bytes little-endian into words,
// flushing a partial word after an idle timeout
module byte_packer_clkb
  import byte_packer_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                                     clkb,
  input  logic                                     resetb_clkb,
  input  logic                                     empty_clkb,
  input  logic [BYTE_W-1:0]                        dout_clkb,
  output logic                                     rd_en_clkb,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]         word_clkb,
  output logic [word_bytes_w(BYTES_PER_WORD)-1:0]  word_bytes_clkb,
  output logic                                     word_valid_clkb,
  input  logic                                     word_ready_clkb
);
  localparam int N = BYTES_PER_WORD;
  localparam int CW = word_bytes_w(N);
  logic [BYTE_W*N-1:0] acc, acc_nxt;
  logic [CW-1:0] acc_cnt;
  logic rd_pending, out_free, partial, xfer_full, xfer_flush, xfer, hit;
  assign out_free = !word_valid_clkb || word_ready_clkb;
  assign partial = acc_cnt != '0 && acc_cnt < CW'(N);
  assign xfer_full = acc_cnt == CW'(N) && out_free;
  assign xfer_flush = hit && partial && !rd_pending && out_free;
  assign xfer = xfer_full || xfer_flush;
  assign rd_en_clkb = !empty_clkb && ((acc_cnt + CW'(rd_pending)) < CW'(N) || xfer_full);
  // Clearing on transfer keeps lanes above acc_cnt zero, so partial words need no masking.
  always_comb begin
    acc_nxt = xfer ? '0 : acc;
    for (int i = 0; i < N; i++)
      if (rd_pending && (xfer ? i == 0 : acc_cnt == CW'(i))) acc_nxt[BYTE_W*i +: BYTE_W] = dout_clkb;
  end
  always_ff @(posedge clkb or negedge resetb_clkb)
    if (!resetb_clkb) begin
      acc <= '0;
      acc_cnt <= '0;
      rd_pending <= 1'b0;
      word_clkb <= '0;
      word_bytes_clkb <= '0;
      word_valid_clkb <= 1'b0;
    end else begin
      acc <= acc_nxt;
      acc_cnt <= xfer ? CW'(rd_pending) : acc_cnt + CW'(rd_pending);
      rd_pending <= rd_en_clkb;
      if (xfer) begin
        word_clkb <= acc;
        word_bytes_clkb <= acc_cnt;
        word_valid_clkb <= 1'b1;
      end else if (word_ready_clkb) word_valid_clkb <= 1'b0;
    end
  idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_idle (
    .clkb        (clkb),
    .resetb_clkb (resetb_clkb),
    .clr         (rd_pending || xfer || !partial),
    .en          (partial),
    .hit         (hit)
  );
endmodule
